branch_predictor_bht: RTL and testbench

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

---
 rtl/branch_predictor_bht.sv | 166 ++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
// Branch history table with saturating counters plus a tagged target buffer.
// The fetch stage reads a prediction combinationally. The decode stage
// resolves branches and writes back counters, targets and global history.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   IF_pc_i             fetch PC to predict
//   IF_pred_o           predicted taken (counter MSB set and tag hit)
//   IF_target_o         predicted target, zero when not predicted taken
//   IF_ghr_o            global history snapshot, travels down the pipe
//   ID_update_i         a branch/jal/jalr resolved in ID this cycle
//   ID_pc_i             PC of the resolved instruction
//   ID_ghr_i            history snapshot that travelled with it
//   ID_br_en_i          resolved taken
//   ID_branch_pc_i      resolved target
//   ID_pred_i           prediction that was made at fetch
//   ID_mispredict_o     flush request to IF/ID
//   branch_count_o      saturating count of resolved updates
//   mispredict_count_o  saturating count of mispredicts
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int width    = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 6,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [width-1:0]    IF_pc_i,
  output logic                IF_pred_o,
  output logic [width-1:0]    IF_target_o,
  output logic [GHR_BITS-1:0] IF_ghr_o,
  input  logic                ID_update_i,
  input  logic [width-1:0]    ID_pc_i,
  input  logic [GHR_BITS-1:0] ID_ghr_i,
  input  logic                ID_br_en_i,
  input  logic [width-1:0]    ID_branch_pc_i,
  input  logic                ID_pred_i,
  output logic                ID_mispredict_o,
  output logic [31:0]         branch_count_o,
  output logic [31:0]         mispredict_count_o
);

  localparam int L     = $clog2(ENTRIES);
  localparam int TAG_W = width - L - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(32'd1);
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  // Parameter sanity. The comparison is written with !== so an X-valued
  // parameter fails as well.
  if (((ENTRIES >= 4) && ((ENTRIES & (ENTRIES - 1)) == 0) &&
       (CTR_BITS >= 1) && (CTR_BITS <= 4) &&
       (GHR_BITS >= 1) && (GHR_BITS <= L) &&
       ((MODE == 0) || (MODE == 1)) &&
       (width >= L + 3)) !== 1'b1) begin : g_bad_params
    $error("branch_predictor_bht: illegal parameter set");
  end

  // Table index: word-aligned PC bits, optionally hashed with history.
  function automatic logic [L-1:0] calc_idx(input logic [width-1:0] pc,
                                            input logic [GHR_BITS-1:0] ghr);
    logic [L-1:0] ext;
    ext = '0;
    ext[GHR_BITS-1:0] = ghr;
    if (MODE == 1) begin
      calc_idx = pc[L+1:2] ^ ext;
    end else begin
      calc_idx = pc[L+1:2];
    end
  endfunction

  // Saturating up/down step of a prediction counter.
  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] cur,
                                                   input logic taken);
    if (taken) begin
      ctr_next = (cur == CTR_MAX) ? cur : cur + CTR_ONE;
    end else begin
      ctr_next = (cur == CTR_ZERO) ? cur : cur - CTR_ONE;
    end
  endfunction

  // Shift the resolved outcome into the history; also correct for GHR_BITS=1.
  function automatic logic [GHR_BITS-1:0] ghr_next(input logic [GHR_BITS-1:0] ghr,
                                                   input logic taken);
    logic [GHR_BITS:0] shifted;
    shifted  = {ghr, taken};
    ghr_next = shifted[GHR_BITS-1:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [width-1:0]    r_target [ENTRIES];
  logic [ENTRIES-1:0]  r_valid;
  logic [GHR_BITS-1:0] r_ghr;
  logic [31:0]         r_branch_count;
  logic [31:0]         r_mispredict_count;

  logic [L-1:0] w_if_idx;
  logic [L-1:0] w_id_idx;
  logic         w_if_hit;
  logic         w_if_pred;
  logic         w_mispredict;
  logic         w_unused;

  // Byte-offset bits never take part in indexing.
  assign w_unused = ^{IF_pc_i[1:0], ID_pc_i[1:0]};

  assign w_if_idx  = calc_idx(IF_pc_i, r_ghr);
  // Updates use the snapshot carried with the instruction, never the live GHR.
  assign w_id_idx  = calc_idx(ID_pc_i, ID_ghr_i);
  assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == IF_pc_i[width-1:L+2]);
  assign w_if_pred = r_ctr[w_if_idx][CTR_BITS-1] & w_if_hit;

  assign w_mispredict = ID_update_i & (ID_br_en_i != ID_pred_i);

  assign IF_pred_o          = w_if_pred;
  assign IF_target_o        = w_if_pred ? r_target[w_if_idx] : {width{1'b0}};
  assign IF_ghr_o           = r_ghr;
  assign ID_mispredict_o    = w_mispredict;
  assign branch_count_o     = r_branch_count;
  assign mispredict_count_o = r_mispredict_count;

  // Counters, valid bits, history and statistics; reset wins over update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
      r_valid            <= '0;
      r_ghr              <= '0;
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else if (ID_update_i) begin
      r_ctr[w_id_idx] <= ctr_next(r_ctr[w_id_idx], ID_br_en_i);
      if (ID_br_en_i) begin
        r_valid[w_id_idx] <= 1'b1;
      end
      r_ghr          <= ghr_next(r_ghr, ID_br_en_i);
      r_branch_count <= sat_inc(r_branch_count);
      if (w_mispredict) begin
        r_mispredict_count <= sat_inc(r_mispredict_count);
      end
    end
  end

  // Tag/target payload; needs no reset because the valid bit gates it.
  always_ff @(posedge clk) begin
    if (!rst && ID_update_i && ID_br_en_i) begin
      r_tag[w_id_idx]    <= ID_pc_i[width-1:L+2];
      r_target[w_id_idx] <= ID_branch_pc_i;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        upd;
  logic [31:0] id_pc;
  logic [5:0]  id_ghr;
  logic        br_en;
  logic [31:0] br_pc;
  logic        id_pred;

  logic        pred_b, pred_g;
  logic [31:0] tgt_b, tgt_g;
  logic [5:0]  ghr_b;
  logic [1:0]  ghr_g;
  logic        mis_b, mis_g;
  logic [31:0] bc_b, bc_g, mc_b, mc_g;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = bimodal instance, 1 = gshare (2-bit history).
  int          m_ctr [2][64];
  bit          m_val [2][64];
  int unsigned m_tag [2][64];
  logic [31:0] m_tgt [2][64];
  int unsigned m_ghr [2];
  longint      m_bc, m_mc;

  branch_predictor_bht #(.MODE(0)) u_dut_bim (
    .clk(clk), .rst(rst), .IF_pc_i(if_pc), .IF_pred_o(pred_b), .IF_target_o(tgt_b),
    .IF_ghr_o(ghr_b), .ID_update_i(upd), .ID_pc_i(id_pc), .ID_ghr_i(id_ghr),
    .ID_br_en_i(br_en), .ID_branch_pc_i(br_pc), .ID_pred_i(id_pred),
    .ID_mispredict_o(mis_b), .branch_count_o(bc_b), .mispredict_count_o(mc_b));

  branch_predictor_bht #(.MODE(1), .GHR_BITS(2)) u_dut_gsh (
    .clk(clk), .rst(rst), .IF_pc_i(if_pc), .IF_pred_o(pred_g), .IF_target_o(tgt_g),
    .IF_ghr_o(ghr_g), .ID_update_i(upd), .ID_pc_i(id_pc), .ID_ghr_i(id_ghr[1:0]),
    .ID_br_en_i(br_en), .ID_branch_pc_i(br_pc), .ID_pred_i(id_pred),
    .ID_mispredict_o(mis_g), .branch_count_o(bc_g), .mispredict_count_o(mc_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int midx(int m, logic [31:0] pc, int unsigned g);
    int base;
    base = int'((pc / 4) % 64);
    return (m == 1) ? (base ^ int'(g % 4)) : base;
  endfunction

  function automatic bit mpred(int m, logic [31:0] pc);
    int i;
    i = midx(m, pc, m_ghr[m]);
    return (m_ctr[m][i] >= 2) && m_val[m][i] && (m_tag[m][i] == pc / 256);
  endfunction

  function automatic logic [31:0] mtarget(int m, logic [31:0] pc);
    return mpred(m, pc) ? m_tgt[m][midx(m, pc, m_ghr[m])] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        m_ctr[m][i] = 1;
        m_val[m][i] = 1'b0;
      end
      m_ghr[m] = 0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_clock();
    int i;
    if (rst) begin
      model_reset();
    end else if (upd) begin
      for (int m = 0; m < 2; m++) begin
        i = midx(m, id_pc, id_ghr);
        if (br_en) begin
          if (m_ctr[m][i] < 3) m_ctr[m][i]++;
          m_val[m][i] = 1'b1;
          m_tag[m][i] = id_pc / 256;
          m_tgt[m][i] = br_pc;
        end else begin
          if (m_ctr[m][i] > 0) m_ctr[m][i]--;
        end
      end
      m_ghr[0] = (m_ghr[0] * 2 + br_en) % 64;
      m_ghr[1] = (m_ghr[1] * 2 + br_en) % 4;
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (br_en != id_pred && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_mis;
    exp_mis = upd && (br_en != id_pred);
    check("pred_bim", pred_b, mpred(0, if_pc));
    check("tgt_bim",  tgt_b,  mtarget(0, if_pc));
    check("ghr_bim",  ghr_b,  m_ghr[0]);
    check("mis_bim",  mis_b,  exp_mis);
    check("bc_bim",   bc_b,   m_bc);
    check("mc_bim",   mc_b,   m_mc);
    check("pred_gsh", pred_g, mpred(1, if_pc));
    check("tgt_gsh",  tgt_g,  mtarget(1, if_pc));
    check("ghr_gsh",  ghr_g,  m_ghr[1]);
    check("mis_gsh",  mis_g,  exp_mis);
    check("bc_gsh",   bc_g,   m_bc);
    check("mc_gsh",   mc_g,   m_mc);
  endtask

  // One cycle: drive at negedge, check combinational view, clock, update model.
  task automatic step(input bit r, input bit u, input logic [31:0] pc, input logic [5:0] g,
                      input bit b, input logic [31:0] t, input bit p, input logic [31:0] q);
    rst = r; upd = u; id_pc = pc; id_ghr = g; br_en = b; br_pc = t; id_pred = p; if_pc = q;
    #1;
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] q);
    step(1'b0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, q);
  endtask

  initial begin
    rst = 1'b1; upd = 1'b0; id_pc = '0; id_ghr = '0; br_en = 1'b0;
    br_pc = '0; id_pred = 1'b0; if_pc = 32'h60;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Held in reset: nothing predicted.
    step(1'b1, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'h60);
    idle(32'h60);
    check("rst_pred", pred_b, 1'b0);
    check("rst_tgt",  tgt_b,  32'd0);
    check("rst_cnt",  bc_b,   32'd0);

    // Two taken updates at 0x60 -> 0x80; first one was mispredicted.
    step(1'b0, 1'b1, 32'h60, 6'd0, 1'b1, 32'h80, mpred(0, 32'h60), 32'h60);
    step(1'b0, 1'b1, 32'h60, 6'd0, 1'b1, 32'h80, mpred(0, 32'h60), 32'h60);
    idle(32'h60);
    check("train_pred", pred_b, 1'b1);
    check("train_tgt",  tgt_b,  32'h80);
    check("train_mc",   mc_b,   32'd1);

    // Saturate at 3, one not-taken leaves it at 2 (still taken).
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 32'h60, 6'd0, 1'b1, 32'h80, mpred(0, 32'h60), 32'h60);
    step(1'b0, 1'b1, 32'h60, 6'd0, 1'b0, 32'h0, mpred(0, 32'h60), 32'h60);
    idle(32'h60);
    check("sat_pred", pred_b, 1'b1);

    // Same index, different tag: no prediction.
    idle(32'h160);
    check("alias_pred", pred_b, 1'b0);

    // Gshare history and snapshot-based update index.
    step(1'b1, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'h60);
    step(1'b0, 1'b1, 32'h100, 6'd0, 1'b1, 32'h44, 1'b0, 32'h60);
    step(1'b0, 1'b1, 32'h100, 6'd0, 1'b0, 32'h0, 1'b0, 32'h60);
    idle(32'h60);
    check("ghr_10", ghr_g, 2'b10);
    step(1'b0, 1'b1, 32'h60, 6'd1, 1'b1, 32'h90, 1'b0, 32'h60);
    idle(32'h60);
    check("gsh_hash_pred", pred_g, 1'b1);
    check("gsh_hash_tgt",  tgt_g,  32'h90);

    // Reset beats a simultaneous update.
    step(1'b1, 1'b1, 32'h60, 6'd0, 1'b1, 32'h80, 1'b0, 32'h60);
    idle(32'h60);
    check("rst_upd_bc",   bc_b,   32'd0);
    check("rst_upd_pred", pred_b, 1'b0);
    check("rst_upd_ghr",  ghr_g,  2'b00);

    // Randomized traffic over a small PC pool to force aliasing.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, q, t;
      bit r, u, b, p;
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      q  = ($urandom_range(0, 1) == 0) ? pc
           : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
      t  = $urandom & 32'hFFFF_FFFC;
      r  = ($urandom_range(0, 60) == 0);
      u  = ($urandom_range(0, 3) != 0);
      b  = $urandom_range(0, 1);
      p  = ($urandom_range(0, 1) == 0) ? mpred(0, pc) : 1'($urandom_range(0, 1));
      step(r, u, pc, 6'($urandom_range(0, 63)), b, t, p, q);
    end
    idle(32'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
